// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port, the shared-memory port
// and the status outputs of the two-requester memory arbiter.
//   master : the arbiter's view (drives acks, read data, the memory request, err, stall)
//   slave  : the environment's view (the requesters and the shared memory)
interface mem_arbiter_if;
    // instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    // data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    // shared-memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    // status
    logic        err;
    logic        stall;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, err, stall
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, err, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester and
// a data requester. One access is in flight at a time; the winner's address,
// write enable and write data are latched at grant and held for the whole access.
// An access that sees no mem_ready for MAX_WAIT busy cycles is acked with err.
//
// Optional build macro MEM_ARB_RR_EN:
//   undefined -> fixed priority, data wins a simultaneous request
//   defined   -> round-robin, the requester not served by the last grant wins
module mem_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic          pick_d;
    logic          any_req;
    logic          ack_now;

    assign any_req = bus.i_req | bus.d_req;
    assign ack_now = bus.i_ack | bus.d_ack;

`ifdef MEM_ARB_RR_EN
    // 1 when the most recent grant went to the data port
    logic last_d_reg;

    // Round-robin winner: data wins unless fetch also asks and data had the last grant
    always_comb pick_d = bus.d_req & (~bus.i_req | ~last_d_reg);
`else
    // Fixed-priority winner: data always beats fetch
    always_comb pick_d = bus.d_req;
`endif

    // A request is still outstanding unless its ack is being shown this cycle
    assign bus.stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

    // Arbitration FSM with registered acks, err, memory request and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_reg    <= 1'b0;
`endif
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // No grant while an ack is showing: the finished requester
                    // still holds its request during that cycle.
                    if (any_req && !ack_now) begin
                        wait_cnt_reg <= '0;
                        bus.mem_req  <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_d_reg   <= pick_d;
`endif
                        if (pick_d) begin
                            state_reg     <= DBUSY;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            state_reg     <= IBUSY;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.i_addr;
                            bus.mem_wdata <= '0;
                        end
                    end
                end
                IBUSY, DBUSY: begin
                    // mem_ready takes precedence over the timeout, so a response
                    // in the last allowed busy cycle still completes normally.
                    if (bus.mem_ready) begin
                        state_reg   <= IDLE;
                        bus.mem_req <= 1'b0;
                        if (state_reg == IBUSY) begin
                            bus.i_ack   <= 1'b1;
                            bus.i_rdata <= bus.mem_rdata;
                        end else begin
                            bus.d_ack <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.d_rdata <= bus.mem_rdata;
                            end
                        end
                    end else if (wait_cnt_reg == CW'(MAX_WAIT - 1)) begin
                        // MAX_WAIT busy cycles without mem_ready: give up, read data untouched
                        state_reg   <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.err     <= 1'b1;
                        if (state_reg == IBUSY) begin
                            bus.i_ack <= 1'b1;
                        end else begin
                            bus.d_ack <= 1'b1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized two-requester traffic against a memory responder whose
// latency is a fixed function of the address, checked by a scoreboard monitor; then
// short directed sequences for wait states, timeout, mid-access deassert and reset.
module tb_mem_arbiter;

    localparam int MW = 6;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          busy;
    } exp_t;

    logic clk;
    logic reset;
    mem_arbiter_if bus();

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t iq[$];
    exp_t dq[$];

    logic [31:0] ref_dmem [256];
    logic [31:0] resp_mem [256];
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;

    bit          mon_en;
    bit          resp_en;
    logic        dir_ready;
    logic [31:0] dir_rdata;
    int          rcnt;

    logic prev_ireq, prev_dreq, prev_ack, prev_mem_req;
    logic model_last_d, owner_d, w_exp, any_ack;
    int   busy;
    exp_t cur, done_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory latency is a property of the address: ready in busy cycle lat+1
    function automatic int lat_of(input logic [31:0] a);
        return int'(a[9:2]) % (MW + 3);
    endfunction

    // Fetch space is read-only with address-derived contents
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random fetch traffic; expected response pushed at issue time
    task automatic i_requester(input int n);
        exp_t        e;
        logic [31:0] a;
        int          gap, w;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            a = 32'h1000 | (32'($urandom_range(0, 255)) << 2);
            e.addr  = a;
            e.we    = 1'b0;
            e.wdata = '0;
            e.err   = lat_of(a) >= MW;
            e.busy  = e.err ? MW : lat_of(a) + 1;
            e.rdata = e.err ? exp_ird : rom(a);
            exp_ird = e.rdata;
            iq.push_back(e);
            bus.i_addr = a;
            bus.i_req  = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (!bus.i_ack && w < 200);
            if (!bus.i_ack) chk("i_ack_wait", 32'(w), 32'(0));
            bus.i_req = 1'b0;
        end
    endtask

    // Random load/store traffic; the model memory follows successful stores
    task automatic d_requester(input int n);
        exp_t        e;
        logic [31:0] a;
        logic [7:0]  idx;
        int          gap, w;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            idx     = 8'($urandom_range(0, 255));
            a       = 32'h2000 | (32'(idx) << 2);
            e.addr  = a;
            e.we    = 1'($urandom_range(0, 1));
            e.wdata = $urandom;
            e.err   = lat_of(a) >= MW;
            e.busy  = e.err ? MW : lat_of(a) + 1;
            if (e.we) begin
                if (!e.err) ref_dmem[idx] = e.wdata;
                e.rdata = exp_drd;
            end else begin
                e.rdata = e.err ? exp_drd : ref_dmem[idx];
            end
            exp_drd = e.rdata;
            dq.push_back(e);
            bus.d_addr  = a;
            bus.d_we    = e.we;
            bus.d_wdata = e.wdata;
            bus.d_req   = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (!bus.d_ack && w < 200);
            if (!bus.d_ack) chk("d_ack_wait", 32'(w), 32'(0));
            bus.d_req = 1'b0;
        end
    endtask

    // Memory responder: address-timed ready while busy, random ready noise while idle
    always @(negedge clk) begin
        if (resp_en) begin
            if (bus.mem_req) begin
                if (rcnt == lat_of(bus.mem_addr)) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        resp_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
                        bus.mem_rdata = $urandom;
                    end else if (bus.mem_addr[13]) begin
                        bus.mem_rdata = resp_mem[bus.mem_addr[9:2]];
                    end else begin
                        bus.mem_rdata = rom(bus.mem_addr);
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
                rcnt++;
            end else begin
                rcnt = 0;
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
        end else begin
            rcnt = 0;
            bus.mem_ready = dir_ready;
            bus.mem_rdata = dir_rdata;
        end
    end

    // Scoreboard monitor: checks grants against the arbitration policy and pops on acks
    always @(negedge clk) begin
        if (mon_en) begin
            any_ack = bus.i_ack | bus.d_ack;
            chk("err_without_ack", 32'(bus.err & ~any_ack), 32'(0));
            if (!prev_mem_req)
                chk("grant_taken", 32'(bus.mem_req), 32'(!prev_ack && (prev_ireq || prev_dreq)));
            if (bus.mem_req && !prev_mem_req) begin
`ifdef MEM_ARB_RR_EN
                w_exp = prev_dreq && (!prev_ireq || !model_last_d);
`else
                w_exp = prev_dreq;
`endif
                model_last_d = w_exp;
                owner_d      = w_exp;
                busy         = 1;
                chk("winner_is_data", 32'(bus.mem_addr[13]), 32'(w_exp));
                if (w_exp ? (dq.size() > 0) : (iq.size() > 0)) begin
                    if (w_exp) cur = dq[0];
                    else       cur = iq[0];
                    chk("grant_addr", bus.mem_addr, cur.addr);
                    chk("grant_we", 32'(bus.mem_we), 32'(cur.we));
                    if (cur.we) chk("grant_wdata", bus.mem_wdata, cur.wdata);
                end
            end else if (bus.mem_req) begin
                busy++;
                chk("addr_stable", bus.mem_addr, cur.addr);
            end
            if (any_ack) begin
                chk("ack_port_is_data", 32'(bus.d_ack), 32'(owner_d));
                chk("ack_both", 32'(bus.i_ack & bus.d_ack), 32'(0));
                if (bus.d_ack && dq.size() > 0) begin
                    done_e = dq.pop_front();
                    chk("d_rdata", bus.d_rdata, done_e.rdata);
                    chk("d_err", 32'(bus.err), 32'(done_e.err));
                    chk("d_busy", 32'(busy), 32'(done_e.busy));
                    $display("[TB] D %s addr=%h rdata=%h err=%0d busy=%0d",
                             done_e.we ? "st" : "ld", done_e.addr, bus.d_rdata, bus.err, busy);
                end else if (bus.i_ack && iq.size() > 0) begin
                    done_e = iq.pop_front();
                    chk("i_rdata", bus.i_rdata, done_e.rdata);
                    chk("i_err", 32'(bus.err), 32'(done_e.err));
                    chk("i_busy", 32'(busy), 32'(done_e.busy));
                    $display("[TB] I fetch addr=%h rdata=%h err=%0d busy=%0d",
                             done_e.addr, bus.i_rdata, bus.err, busy);
                end else begin
                    chk("ack_with_empty_queue", 32'(1), 32'(0));
                end
            end
            prev_ireq    = bus.i_req;
            prev_dreq    = bus.d_req;
            prev_ack     = any_ack;
            prev_mem_req = bus.mem_req;
        end else begin
            prev_ireq    = 1'b0;
            prev_dreq    = 1'b0;
            prev_ack     = 1'b0;
            prev_mem_req = 1'b0;
        end
    end

    // Global bound on run length
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exceeded");
        $fatal(1, "watchdog");
    end

    int cnt;

    initial begin
        reset       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        mon_en      = 1'b0;
        resp_en     = 1'b0;
        dir_ready   = 1'b0;
        dir_rdata   = '0;
        exp_ird     = '0;
        exp_drd     = '0;
        model_last_d = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_dmem[i] = $urandom;
            resp_mem[i] = ref_dmem[i];
        end
        tick();
        tick();

        // reset state
        chk("rst_mem_req",   32'(bus.mem_req), 0);
        chk("rst_mem_we",    32'(bus.mem_we), 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_i_ack",     32'(bus.i_ack), 0);
        chk("rst_d_ack",     32'(bus.d_ack), 0);
        chk("rst_err",       32'(bus.err), 0);
        chk("rst_i_rdata",   bus.i_rdata, 0);
        chk("rst_d_rdata",   bus.d_rdata, 0);
        chk("rst_stall",     32'(bus.stall), 0);

        // randomized concurrent traffic
        reset   = 1'b1;
        mon_en  = 1'b1;
        resp_en = 1'b1;
        fork
            i_requester(40);
            d_requester(40);
        join
        repeat (3) tick();
        chk("iq_drained", 32'(iq.size()), 0);
        chk("dq_drained", 32'(dq.size()), 0);
        mon_en  = 1'b0;
        resp_en = 1'b0;

        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // wait states with the fetch address changed mid-access
        bus.i_addr = 32'h1234_5670;
        bus.i_req  = 1'b1;
        tick();
        chk("w_mem_req", 32'(bus.mem_req), 1);
        chk("w_addr",    bus.mem_addr, 32'h1234_5670);
        chk("w_we",      32'(bus.mem_we), 0);
        chk("w_stall",   32'(bus.stall), 1);
        bus.i_addr = 32'hFFFF_0000;
        repeat (3) begin
            tick();
            chk("w_addr_held", bus.mem_addr, 32'h1234_5670);
            chk("w_stall_busy", 32'(bus.stall), 1);
            chk("w_no_ack", 32'(bus.i_ack), 0);
        end
        dir_ready = 1'b1;
        dir_rdata = 32'hCAFE_F00D;
        tick();
        chk("w_ack",        32'(bus.i_ack), 1);
        chk("w_err",        32'(bus.err), 0);
        chk("w_rdata",      bus.i_rdata, 32'hCAFE_F00D);
        chk("w_stall_ack",  32'(bus.stall), 0);
        chk("w_req_drop",   32'(bus.mem_req), 0);
        dir_ready = 1'b0;
        bus.i_req = 1'b0;
        tick();
        chk("w_ack_pulse",  32'(bus.i_ack), 0);

        // timeout on a fetch
        bus.i_addr = 32'h0000_1000;
        bus.i_req  = 1'b1;
        tick();
        cnt = 1;
        while (bus.mem_req && cnt < 50) begin
            tick();
            if (bus.mem_req) cnt++;
        end
        chk("to_busy_cycles", 32'(cnt), 32'(MW));
        chk("to_ack",         32'(bus.i_ack), 1);
        chk("to_err",         32'(bus.err), 1);
        chk("to_rdata_kept",  bus.i_rdata, 32'hCAFE_F00D);
        bus.i_req = 1'b0;
        tick();
        chk("to_err_pulse",   32'(bus.err), 0);
        chk("to_idle",        32'(bus.mem_req), 0);

        // store whose request drops mid-access
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0080;
        bus.d_wdata = 32'h1234_5678;
        tick();
        chk("st_we",    32'(bus.mem_we), 1);
        chk("st_addr",  bus.mem_addr, 32'h0000_0080);
        chk("st_wdata", bus.mem_wdata, 32'h1234_5678);
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        tick();
        chk("st_req_kept",   32'(bus.mem_req), 1);
        chk("st_we_kept",    32'(bus.mem_we), 1);
        chk("st_wdata_kept", bus.mem_wdata, 32'h1234_5678);
        dir_ready = 1'b1;
        tick();
        chk("st_ack",        32'(bus.d_ack), 1);
        chk("st_rdata_kept", bus.d_rdata, 0);
        dir_ready = 1'b0;
        tick();

        // reset during a load abandons it; the held request is regranted after release
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0040;
        tick();
        chk("rm_granted", 32'(bus.mem_req), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rm_async_drop", 32'(bus.mem_req), 0);
        tick();
        chk("rm_no_ack", 32'(bus.d_ack), 0);
        reset = 1'b1;
        tick();
        chk("rm_regrant",  32'(bus.mem_req), 1);
        chk("rm_addr",     bus.mem_addr, 32'h0000_0040);
        dir_ready = 1'b1;
        dir_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ld_ack",   32'(bus.d_ack), 1);
        chk("ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        chk("ld_we",    32'(bus.mem_we), 0);
        bus.d_req = 1'b0;
        dir_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
